// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared types and constants for the M-extension issue
//               controller (funct3 encoding, sequencer states, divide
//               overflow constant, multiplier signedness classes).
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

  // RISC-V M-extension funct3 encoding
  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    RESP = 2'd3
  } muldiv_seq_state_t;

  // Most negative signed dividend; with divisor -1 the quotient overflows
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  // Operand signedness of a multiply: 2'b00 signed x signed,
  // 2'b01 signed x unsigned, 2'b11 unsigned x unsigned. mul shares the
  // signed x signed class because its low half does not depend on sign.
  function automatic logic [1:0] mul_sign_class(input logic [2:0] f3);
    logic [1:0] cls;
    case (f3)
      F3_MULHSU: cls = 2'b01;
      F3_MULHU:  cls = 2'b11;
      default:   cls = 2'b00;
    endcase
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_special_detect.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_special_detect
// Description : Combinational detection of RISC-V divide corner cases
//               (divide by zero, signed overflow) and their fixed results.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_special_detect
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            is_special_o,
  output logic [XLEN-1:0] special_result_o
);

  localparam logic [XLEN-1:0] c_ovf_dividend = XLEN'(DIV_OVF_DIVIDEND);

  logic w_is_div;
  logic w_signed;
  logic w_is_rem;
  logic w_div_zero;
  logic w_ovf;

  assign w_is_div   = funct3_i[2];
  assign w_signed   = ~funct3_i[0];
  assign w_is_rem   = funct3_i[1];
  assign w_div_zero = (b_i == '0);
  assign w_ovf      = w_signed && (a_i == c_ovf_dividend) && (b_i == '1);

  assign is_special_o = w_is_div && (w_div_zero || w_ovf);

  // Architecturally defined results; divide by zero takes precedence
  always_comb begin
    special_result_o = '0;
    if (w_div_zero) begin
      special_result_o = w_is_rem ? a_i : '1;
    end else if (w_ovf) begin
      special_result_o = w_is_rem ? '0 : c_ovf_dividend;
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Issue controller between EX and the shared multiplier /
//               iterative divider. Latches one op, holds the unit start level
//               until done, selects the result, short-circuits divide corner
//               cases, stalls the pipeline while busy and aborts via a
//               watchdog.
//               Optional feature macro: MULDIV_PAIR_FUSE_EN (reuse the last
//               64-bit product for a following multiply on the same operands).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  output logic              stall,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              err,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  output logic [2:0]        mul_sign,
  output logic              mul_start,
  input  logic [2*XLEN-1:0] mul_product,
  input  logic              mul_done,
  output logic [XLEN-1:0]   div_a,
  output logic [XLEN-1:0]   div_b,
  output logic              div_signed,
  output logic              div_start,
  input  logic [XLEN-1:0]   div_quot,
  input  logic [XLEN-1:0]   div_rem,
  input  logic              div_done
);

  localparam int                  c_wdog_w    = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(WDOG_CYCLES - 1);
  localparam logic [c_wdog_w-1:0] c_wdog_one  = c_wdog_w'(1);

  muldiv_seq_state_t   state_q;
  logic [2:0]          funct3_q;
  logic                req_ready_q;
  logic                stall_q;
  logic                resp_valid_q;
  logic [XLEN-1:0]     resp_data_q;
  logic                err_q;
  logic [XLEN-1:0]     mul_a_q;
  logic [XLEN-1:0]     mul_b_q;
  logic [2:0]          mul_sign_q;
  logic                mul_start_q;
  logic [XLEN-1:0]     div_a_q;
  logic [XLEN-1:0]     div_b_q;
  logic                div_signed_q;
  logic                div_start_q;
  logic [c_wdog_w-1:0] wdog_q;

  logic                w_is_special;
  logic [XLEN-1:0]     w_special_result;
  logic                w_busy;
  logic                w_unit_done;
  logic                w_wdog_expire;
  logic                w_fuse_hit;
  logic [XLEN-1:0]     w_fuse_result;

  muldiv_special_detect #(
    .XLEN (XLEN)
  ) u_special_detect (
    .funct3_i         (req_funct3),
    .a_i              (req_a),
    .b_i              (req_b),
    .is_special_o     (w_is_special),
    .special_result_o (w_special_result)
  );

  assign w_busy        = (state_q == MUL) || (state_q == DIV);
  assign w_unit_done   = ((state_q == MUL) && mul_done) || ((state_q == DIV) && div_done);
  // A done arriving in the last allowed cycle still completes the op
  assign w_wdog_expire = w_busy && !w_unit_done && (wdog_q == c_wdog_last);

`ifdef MULDIV_PAIR_FUSE_EN
  logic              cache_valid_q;
  logic [XLEN-1:0]   cache_a_q;
  logic [XLEN-1:0]   cache_b_q;
  logic [1:0]        cache_sign_q;
  logic [2*XLEN-1:0] cache_prod_q;

  assign w_fuse_hit    = cache_valid_q && !req_funct3[2] &&
                         (req_a == cache_a_q) && (req_b == cache_b_q) &&
                         (cache_sign_q == mul_sign_class(req_funct3));
  assign w_fuse_result = (req_funct3 == F3_MUL) ? cache_prod_q[XLEN-1:0]
                                                : cache_prod_q[2*XLEN-1:XLEN];

  // Remember the last completed full product; any abort discards it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid_q <= 1'b0;
      cache_a_q     <= '0;
      cache_b_q     <= '0;
      cache_sign_q  <= '0;
      cache_prod_q  <= '0;
    end else if (flush || w_wdog_expire) begin
      cache_valid_q <= 1'b0;
    end else if ((state_q == MUL) && mul_done) begin
      cache_valid_q <= 1'b1;
      cache_a_q     <= mul_a_q;
      cache_b_q     <= mul_b_q;
      cache_sign_q  <= mul_sign_class(funct3_q);
      cache_prod_q  <= mul_product;
    end
  end
`else
  assign w_fuse_hit    = 1'b0;
  assign w_fuse_result = '0;
`endif

  // Sequencer: accept, drive the selected unit, capture result, respond
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      funct3_q     <= '0;
      req_ready_q  <= 1'b0;
      stall_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_sign_q   <= '0;
      mul_start_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signed_q <= 1'b0;
      div_start_q  <= 1'b0;
      wdog_q       <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          wdog_q      <= '0;
          if (req_valid && !flush) begin
            funct3_q    <= req_funct3;
            req_ready_q <= 1'b0;
            if (!req_funct3[2]) begin
              if (w_fuse_hit) begin
                resp_data_q  <= w_fuse_result;
                resp_valid_q <= 1'b1;
                state_q      <= RESP;
              end else begin
                mul_a_q     <= req_a;
                mul_b_q     <= req_b;
                mul_sign_q  <= req_funct3;
                mul_start_q <= 1'b1;
                stall_q     <= 1'b1;
                state_q     <= MUL;
              end
            end else if (w_is_special) begin
              resp_data_q  <= w_special_result;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              div_a_q      <= req_a;
              div_b_q      <= req_b;
              div_signed_q <= ~req_funct3[0];
              div_start_q  <= 1'b1;
              stall_q      <= 1'b1;
              state_q      <= DIV;
            end
          end
        end
        MUL, DIV: begin
          if (flush || w_wdog_expire) begin
            err_q       <= w_wdog_expire;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            stall_q     <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (w_unit_done) begin
            if (state_q == MUL) begin
              resp_data_q <= (funct3_q == F3_MUL) ? mul_product[XLEN-1:0]
                                                  : mul_product[2*XLEN-1:XLEN];
            end else begin
              resp_data_q <= funct3_q[1] ? div_rem : div_quot;
            end
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
            stall_q      <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            wdog_q <= wdog_q + c_wdog_one;
          end
        end
        RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign stall      = stall_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err        = err_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_sign   = mul_sign_q;
  // Start levels fall in the very cycle a flush or the unit's done appears
  assign mul_start  = mul_start_q & ~flush & ~mul_done;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign div_signed = div_signed_q;
  assign div_start  = div_start_q & ~flush & ~div_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer with behavioural
//               multiplier/divider models and an arithmetic reference model.
//               Honours MULDIV_PAIR_FUSE_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

  localparam int c_wdog = 64;
  localparam logic [2:0] c_f3_mul = 3'd0, c_f3_mulh = 3'd1, c_f3_mulhsu = 3'd2,
                         c_f3_mulhu = 3'd3, c_f3_div = 3'd4, c_f3_divu = 3'd5,
                         c_f3_rem = 3'd6, c_f3_remu = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        stall, resp_valid, err;
  logic [31:0] resp_data;
  logic [31:0] mul_a, mul_b;
  logic [2:0]  mul_sign;
  logic        mul_start;
  logic [63:0] mul_product = '0;
  logic        mul_done = 1'b0;
  logic [31:0] div_a, div_b;
  logic        div_signed, div_start;
  logic [31:0] div_quot = '0;
  logic [31:0] div_rem = '0;
  logic        div_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Results of the last run_op
  logic [31:0] op_data;
  int          op_resp_cyc, op_start_cyc, op_stall_err;
  logic        op_extra_resp, op_stall_at_resp;

  muldiv_sequencer #(.XLEN(32), .WDOG_CYCLES(c_wdog)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .err(err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sign(mul_sign), .mul_start(mul_start),
    .mul_product(mul_product), .mul_done(mul_done),
    .div_a(div_a), .div_b(div_b), .div_signed(div_signed), .div_start(div_start),
    .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Multiplier unit model: interprets the sign select as the multiply funct3
  function automatic logic [63:0] unit_prod(input logic [2:0] s, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = (s != 3'd3) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (s <= 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Reference result from the RISC-V M-extension rules
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] up;
    int ia, ib, iq;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: return a * b;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        iq = ia / ib; return iq;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        iq = ia % ib; return iq;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op and play the units; lat = cycles of start before done (0 = never)
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int lat);
    int w;
    op_data = 'x; op_resp_cyc = 0; op_start_cyc = 0; op_stall_err = 0;
    op_extra_resp = 1'b0; op_stall_at_resp = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      mul_done = 1'b0; div_done = 1'b0;
      if (resp_valid) begin
        op_resp_cyc = c; op_data = resp_data; op_stall_at_resp = stall;
        break;
      end
      if (mul_start) begin
        op_start_cyc++;
        if (!stall) op_stall_err++;
        if (op_start_cyc == lat) begin
          mul_product = unit_prod(mul_sign, mul_a, mul_b);
          mul_done = 1'b1;
        end
      end
      if (div_start) begin
        op_start_cyc++;
        if (!stall) op_stall_err++;
        if (op_start_cyc == lat) begin
          if (div_b == 0) begin div_quot = '1; div_rem = div_a; end
          else if (div_signed) begin
            div_quot = $signed(div_a) / $signed(div_b);
            div_rem  = $signed(div_a) % $signed(div_b);
          end else begin
            div_quot = div_a / div_b; div_rem = div_a % div_b;
          end
          div_done = 1'b1;
        end
      end
    end
    @(negedge clk);
    mul_done = 1'b0; div_done = 1'b0;
    op_extra_resp = resp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, stall, resp_valid, err, mul_start, div_start, div_signed, mul_sign,
         resp_data, mul_a, mul_b, div_a, div_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b stall=%b resp=%b err=%b ms=%b ds=%b data=%h required all zero",
               req_ready, stall, resp_valid, err, mul_start, div_start, resp_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: ready=%b stall=%b required ready=1 stall=0", req_ready, stall);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3 [3] = '{c_f3_mul, c_f3_mulhu, c_f3_mulh};
    logic [31:0] a  [3] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] b  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ex [3] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000};
    for (int i = 0; i < 3; i++) begin
      run_op(f3[i], a[i], b[i], 5);
      n_checks++;
      if (op_data !== ex[i]) begin
        n_fail++;
        $display("FAIL mul_data[%0d]: got %h required %h", i, op_data, ex[i]);
      end
      n_checks++;
      if (op_start_cyc !== 5 || op_resp_cyc !== 6 || op_extra_resp !== 1'b0 ||
          op_stall_err !== 0 || op_stall_at_resp !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_handshake[%0d]: start_cyc=%0d resp_cyc=%0d extra=%b stall_err=%0d stall_at_resp=%b required 5,6,0,0,0",
                 i, op_start_cyc, op_resp_cyc, op_extra_resp, op_stall_err, op_stall_at_resp);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3 [4] = '{c_f3_div, c_f3_rem, c_f3_div, c_f3_rem};
    logic [31:0] a  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      run_op(f3[i], a[i], b[i], 3);
      n_checks++;
      if (op_data !== ex[i] || op_resp_cyc !== 1 || op_start_cyc !== 0) begin
        n_fail++;
        $display("FAIL special[%0d]: data=%h resp_cyc=%0d start_cyc=%0d required %h,1,0",
                 i, op_data, op_resp_cyc, op_start_cyc, ex[i]);
      end
    end
  endtask

  task automatic test_divu();
    run_op(c_f3_divu, 32'd100, 32'd7, 10);
    n_checks++;
    if (op_data !== 32'd14 || op_start_cyc !== 10 || op_resp_cyc !== 11) begin
      n_fail++;
      $display("FAIL divu: data=%0d start_cyc=%0d resp_cyc=%0d required 14,10,11",
               op_data, op_start_cyc, op_resp_cyc);
    end
    run_op(c_f3_remu, 32'd100, 32'd7, 10);
    n_checks++;
    if (op_data !== 32'd2 || op_extra_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL remu: data=%0d extra_resp=%b required 2,0", op_data, op_extra_resp);
    end
  endtask

  task automatic test_flush();
    logic pre_start;
    int   late_resp;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = c_f3_mul; req_a = 32'd9; req_b = 32'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    pre_start = mul_start;
    flush = 1'b1;
    #1;
    n_checks++;
    if (pre_start !== 1'b1 || mul_start !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_drop: before=%b after=%b required 1,0", pre_start, mul_start);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || mul_start !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_idle: ready=%b stall=%b mul_start=%b required 1,0,0",
               req_ready, stall, mul_start);
    end
    mul_product = 64'h1234; mul_done = 1'b1;
    late_resp = 0;
    @(negedge clk);
    mul_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) late_resp++;
      @(negedge clk);
    end
    n_checks++;
    if (late_resp !== 0) begin
      n_fail++;
      $display("FAIL flush_late_done: resp_valid cycles=%0d required 0", late_resp);
    end
    // Request together with flush in IDLE is refused
    req_valid = 1'b1; flush = 1'b1; req_funct3 = c_f3_divu; req_a = 32'd50; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || div_start !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_with_req: ready=%b stall=%b div_start=%b resp=%b required 1,0,0,0",
               req_ready, stall, div_start, resp_valid);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, ex;
    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      ex = ref_result(f3, a, b);
      run_op(f3, a, b, $urandom_range(1, 8));
      n_checks++;
      if (op_data !== ex || op_extra_resp !== 1'b0) begin
        n_fail++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h extra=%b required %h",
                 i, f3, a, b, op_data, op_extra_resp, ex);
      end
    end
  endtask

  task automatic test_watchdog();
    int  busy, errs;
    logic ready_at_err;
    busy = 0; errs = 0; ready_at_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = c_f3_div; req_a = 32'd1000; req_b = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (div_start) busy++;
      if (err) begin errs++; ready_at_err = req_ready; break; end
    end
    @(negedge clk);
    if (err) errs++;
    n_checks++;
    if (errs !== 1 || busy !== c_wdog || ready_at_err !== 1'b1 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL watchdog: err_cycles=%0d busy=%0d ready=%b div_start=%b required 1,%0d,1,0",
               errs, busy, c_wdog, ready_at_err, div_start);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = c_f3_divu; req_a = 32'd77; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, stall, resp_valid, err, mul_start, div_start, div_signed,
         resp_data, div_a, div_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_div: ready=%b stall=%b div_start=%b div_a=%h required all zero",
               req_ready, stall, div_start, div_a);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, ex;
    a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    run_op(c_f3_mul, a, b, 5);
    ex = ref_result(c_f3_mul, a, b);
    n_checks++;
    if (op_data !== ex || op_start_cyc !== 5) begin
      n_fail++;
      $display("FAIL b2b_first: data=%h start_cyc=%0d required %h,5", op_data, op_start_cyc, ex);
    end
    run_op(c_f3_mulh, a, b, 5);
    ex = ref_result(c_f3_mulh, a, b);
`ifdef MULDIV_PAIR_FUSE_EN
    n_checks++;
    if (op_data !== ex || op_start_cyc !== 0 || op_resp_cyc !== 1) begin
      n_fail++;
      $display("FAIL b2b_fused: data=%h start_cyc=%0d resp_cyc=%0d required %h,0,1",
               op_data, op_start_cyc, op_resp_cyc, ex);
    end
`else
    n_checks++;
    if (op_data !== ex || op_start_cyc !== 5 || op_resp_cyc !== 6) begin
      n_fail++;
      $display("FAIL b2b_second: data=%h start_cyc=%0d resp_cyc=%0d required %h,5,6",
               op_data, op_start_cyc, op_resp_cyc, ex);
    end
`endif
    // Different signedness on the same operands always goes through the unit
    run_op(c_f3_mulhu, a, b, 4);
    ex = ref_result(c_f3_mulhu, a, b);
    n_checks++;
    if (op_data !== ex || op_start_cyc !== 4) begin
      n_fail++;
      $display("FAIL b2b_mulhu: data=%h start_cyc=%0d required %h,4", op_data, op_start_cyc, ex);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_special();
    test_divu();
    test_flush();
    test_random();
    test_watchdog();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
